data_bus_arbiter: RTL
=====================

Name: data_bus_arbiter

Overview:
Two-master, one-slave arbiter that shares the single memory DataBus between the CPU instruction-fetch port (m0) and the load/store port (m1). It sits between CPUCore and the memory model or controller. It sequences one transaction at a time, holds the grant until the slave completes, and alternates round-robin on contention. A wait-cycle watchdog terminates hung slave accesses with an error.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 16, max BUSY cycles waiting for s_ready before forced error completion (>=2)

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous active-low reset
m0_read  in  1  fetch master read request
m0_write  in  1  fetch master write request
m0_addr  in  ADDR_W  fetch master byte address
m0_wdata  in  DATA_W  fetch master write data
m0_rdata  out  DATA_W  read data returned to m0
m0_ready  out  1  one-cycle completion strobe to m0
m0_err  out  1  timeout flag, valid with m0_ready
m1_read / m1_write / m1_addr / m1_wdata / m1_rdata / m1_ready / m1_err  same as m0, for the load/store master
s_read  out  1  slave read
s_write  out  1  slave write
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_rdata  in  DATA_W  slave read data, valid when s_ready=1
s_ready  in  1  slave completion
grant  out  2  one-hot current owner (01=m0, 10=m1, 00=none)
busy  out  1  high in BUSY0/BUSY1

Behaviour:
- Reset (res=0, async): state=IDLE, last=1 (m0 wins the first tie), wait_cnt=0, grant=00, busy=0. All s_* and m*_ready/err/rdata are 0.
- Request: mX_req = mX_read | mX_write. Each master holds addr/wdata/read/write stable until its mX_ready. If read and write are both high, the access is a write.
- FSM states: IDLE, BUSY0, BUSY1.
- IDLE: one requester goes to BUSYx for that requester. Both requesting: grant the master != last. Grant is registered, so slave signals appear 1 cycle after the request is first seen.
- BUSYx: s_read/s_write/s_addr/s_wdata are driven combinationally from master x. s_read = mx_read & ~mx_write. The other master's signals are ignored.
- Completion: s_ready=1 in BUSYx. mx_ready=1 and mx_rdata=s_rdata in that same cycle (combinational pass-through). last<=x, wait_cnt<=0.
- Next state on completion: the other master requesting goes directly to BUSY(other) (back-to-back, no IDLE bubble). Otherwise go to IDLE, even if x still requests, so x's new request takes 1 IDLE cycle.
- Timeout: wait_cnt increments each BUSY cycle without s_ready. When wait_cnt==TIMEOUT-1 and s_ready=0: mx_ready=1, mx_err=1, mx_rdata=0. s_read/s_write deasserted next cycle. The completion next-state rules apply.
- Non-granted master: ready/err/rdata stay 0.
- A master dropping its request mid-BUSY is a protocol violation. The arbiter keeps the grant until completion or timeout.
- s_ready in IDLE is ignored.
- Async reset mid-transaction aborts immediately. The slave sees s_read/s_write fall with no completion.
- wait_cnt width: $clog2(TIMEOUT)+1, saturating.

Decomposition:
- Shared package bus_pkg: typedef enum ArbState {IDLE, BUSY0, BUSY1}; localparam grant encodings G_NONE/G_M0/G_M1; bus width constants.
- Sub-module arb_rr2: 2-way round-robin picker. Inputs req[1:0] and last; output one-hot pick.
- The FSM, watchdog and muxing stay in data_bus_arbiter.

Test Plan:
- Single read: m0_read=1 addr=0x40, slave ready=1, s_rdata=0x4 → s_read seen cycle+1, m0_ready=1 with m0_rdata=0x00000004 same cycle, grant=01, then IDLE.
- Contention after reset: m0_read and m1_write (addr 0x4C, wdata 0x9) in the same cycle, ready=1 → m0 served first, m1 next cycle back-to-back (s_write=1, s_wdata=0x9), grant 01→10→00.
- Fairness: both masters requesting continuously for 6 transactions → grants strictly alternate 01,10,01,10,01,10.
- Wait states: m1_read with s_ready delayed 3 cycles → s_addr stable 4 cycles; single m1_ready pulse; m0 request during wait is not granted until completion.
- Timeout: TIMEOUT=16, s_ready held 0 → m0_ready=1, m0_err=1, m0_rdata=0 on the 16th BUSY cycle; next cycle s_read=0, busy=0.
- Reset mid-op: res=0 during BUSY1 → grant=00, busy=0, s_write=0 immediately; after res=1, m0 is granted first on a tie.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_M0   = 2'b01;
  localparam logic [1:0] G_M1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
// Purely combinational, no backpressure of its own.
module arb_rr2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = G_NONE;
    if (req == 2'b11) begin
      pick = last ? G_M0 : G_M1;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one slave bus between fetch (m0) and load/store (m1), one access at a time.
// Grant lands 1 cycle after a request; completion is passed straight through; a watchdog forces an error completion.
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_t    state_q;
  logic          last_q;
  logic [1:0]    grant_q;
  logic          busy_q;
  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  logic       m0_req;
  logic       m1_req;
  logic [1:0] pick;
  logic       in_busy;
  logic       sel1;
  logic       timeout_hit;
  logic       done;
  logic       other_req;

  assign m0_req      = m0_read | m0_write;
  assign m1_req      = m1_read | m1_write;
  assign in_busy     = (state_q == BUSY0) || (state_q == BUSY1);
  assign sel1        = (state_q == BUSY1);
  assign timeout_hit = in_busy & ~s_ready & (wait_cnt_q == CW'(TIMEOUT - 1));
  assign done        = in_busy & (s_ready | timeout_hit);
  assign other_req   = sel1 ? m0_req : m1_req;
  assign wait_cnt_d  = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;

  assign grant = grant_q;
  assign busy  = busy_q;

  arb_rr2 u_rr (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .pick (pick)
  );

  // Slave bus follows the owner; read data is zeroed on a forced completion.
  always_comb begin
    s_read   = 1'b0;
    s_write  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (state_q)
      BUSY0: begin
        s_read   = m0_read & ~m0_write;
        s_write  = m0_write;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ready = done;
        m0_err   = timeout_hit;
        m0_rdata = s_ready ? s_rdata : '0;
      end
      BUSY1: begin
        s_read   = m1_read & ~m1_write;
        s_write  = m1_write;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ready = done;
        m1_err   = timeout_hit;
        m1_rdata = s_ready ? s_rdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      grant_q    <= G_NONE;
      busy_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (pick == G_M0) begin
            state_q <= BUSY0;
            grant_q <= G_M0;
            busy_q  <= 1'b1;
          end else if (pick == G_M1) begin
            state_q <= BUSY1;
            grant_q <= G_M1;
            busy_q  <= 1'b1;
          end
        end
        BUSY0, BUSY1: begin
          if (done) begin
            last_q     <= sel1;
            wait_cnt_q <= '0;
            // Hand straight over to a waiting peer; the finishing master re-arbitrates via IDLE.
            if (other_req) begin
              state_q <= sel1 ? BUSY0 : BUSY1;
              grant_q <= sel1 ? G_M0 : G_M1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              grant_q <= G_NONE;
              busy_q  <= 1'b0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= G_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
